gpio_wb_arbiter: RTL and testbench
==================================

# gpio_wb_arbiter

Round-robin Wishbone arbiter that shares the single slave port of `gpio_port` among `N_REQ` on-chip requesters, such as a CPU bridge, a pattern sequencer and a debug port. Each requester issues one register access at a time through a simple req/done handshake. The arbiter serialises these into classic (non-pipelined) Wishbone cycles toward the GPIO slave and returns read data and completion status to the granted requester.

## Interface
- `N_REQ`, 4: number of requesters; legal range 2..8.
- `TIMEOUT`, 255: ack watchdog limit in clock cycles; used only with `GPIO_WB_ARB_TIMEOUT_EN`.
- `wb_clk_i`  in  1  single clock; all logic is rising-edge.
- `rst_n_i`  in  1  reset, asynchronous assert, active-low.
- `req_i`  in  N_REQ  level request per requester; held until its `done_o` bit.
- `we_i`  in  N_REQ  write enable per requester.
- `addr_i`  in  N_REQ*3  word address per requester; slice i is bits [3i+2:3i].
- `data_i`  in  N_REQ*32  write data per requester.
- `sel_i`  in  N_REQ*4  byte selects per requester.
- `done_o`  out  N_REQ  one-cycle completion pulse for the granted requester.
- `err_o`  out  1  valid with `done_o`; 1 means the access timed out.
- `rdata_o`  out  32  read data, shared by all requesters; valid with `done_o`.
- `gnt_o`  out  N_REQ  one-hot grant; nonzero from grant until done.
- `wb_addr_o`, `wb_data_o`, `wb_sel_o`, `wb_we_o`, `wb_cyc_o`, `wb_stb_o`  out  3/32/4/1/1/1  master side toward the `gpio_port` slave.
- `wb_data_i`  in  32  slave read data.
- `wb_ack_i`  in  1  slave acknowledge.

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE, when `req_i` != 0:
  - Pick the first set requester at or after the round-robin pointer `rr_ptr`, wrapping modulo N_REQ.
  - Register its we/addr/data/sel, set `gnt_o`, go to BUS.
- BUS:
  - `wb_cyc_o` = `wb_stb_o` = 1; address, data, sel and we are stable from registers.
  - On `wb_ack_i`=1: capture `wb_data_i` into `rdata_o` (on reads only; writes leave it unchanged), go to DONE.
- DONE:
  - `wb_cyc_o`/`wb_stb_o` = 0; `done_o[g]` = 1 and `err_o` = 0 for one cycle.
  - Clear `gnt_o`; set `rr_ptr` = g+1 mod N_REQ; go to IDLE.
- Fairness: a requester waits at most N_REQ-1 other transactions.
- Requester drops `req_i` while granted: the transaction still completes and `done_o` still pulses; nothing is aborted on the bus.
- Requester keeps `req_i` high in the cycle after `done_o`: treated as a new request and arbitrated normally.
- Stray `wb_ack_i` in IDLE or DONE: ignored.
- Reset values: all outputs 0, `rdata_o` = 0, `rr_ptr` = 0, state = IDLE. Reset asserted mid-BUS drops cyc/stb immediately, asynchronously.

## Timing
- Request seen in IDLE at edge k.
- `wb_cyc_o`/`wb_stb_o` are high from edge k+1.
- Slave acks during the cycle after edge k+a (a ≥ 1).
- `done_o` is high during the cycle after edge k+a+1.
- IDLE is re-entered at edge k+a+2.
- Minimum spacing between back-to-back transactions is 3 cycles, including a mandatory one-cycle bus-idle gap (DONE) between Wishbone cycles.
- No combinational path from `req_i` or `wb_ack_i` to any Wishbone output.

## Configuration
- `GPIO_WB_ARB_TIMEOUT_EN` defined:
  - An 8-bit cycle counter runs in BUS.
  - When it reaches `TIMEOUT` with no ack, go to DONE with `err_o` = 1 and `rdata_o` = 32'hDEAD_0000 | {29'b0, addr}.
  - The counter clears on every BUS entry.
- Undefined: no counter and `err_o` is tied to 0; BUS waits indefinitely.

## Structure
- Shared package `gpio_arb_pkg`:
  - state enum (IDLE/BUS/DONE);
  - constants `GPIO_AW` = 3, `GPIO_DW` = 32, `GPIO_SW` = 4;
  - timeout error pattern.
- Sub-module `gpio_rr_pick`: combinational round-robin picker taking `req`, `ptr` and producing a one-hot grant plus an index. The FSM lives in the top.

## Test plan
- Single write, requester 0: addr 3'h1, data 32'hFFFF0000, sel 4'hF. Required: cyc/stb asserted one cycle after grant, wb bus carries exactly those values, `done_o` = 4'b0001 with `err_o` = 0.
- Simultaneous `req_i` = 4'b1111 held continuously from reset. Required grant order 0,1,2,3,0. Each `done_o` pulses one-hot, with ≥1 idle cycle between cyc assertions.
- Read via requester 2 with the slave returning 32'hCAFE_BEEF after 3 wait cycles. Required: `rdata_o` = 32'hCAFEBEEF exactly in the `done_o[2]` cycle; the total latency matches the Timing section.
- Requester 1 deasserts `req_i` during BUS. Required: the bus cycle still completes on ack, `done_o[1]` pulses, and the next grant goes to requester 2 when it is pending.
- `rst_n_i` pulsed low mid-BUS. Required: `wb_cyc_o`/`wb_stb_o`/`gnt_o` go to 0 without waiting for a clock edge, and the post-reset first grant goes to the lowest pending index.
- With `GPIO_WB_ARB_TIMEOUT_EN`, `TIMEOUT` = 16 and the slave never acking, addr 3'h5. Required: `done_o` after 16 BUS cycles with `err_o` = 1 and `rdata_o` = 32'hDEAD0005, then the arbiter serves the next requester.

Source files
------------

// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the GPIO Wishbone arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package gpio_arb_pkg;

    localparam int GPIO_AW = 3;
    localparam int GPIO_DW = 32;
    localparam int GPIO_SW = 4;

    localparam logic [GPIO_DW-1:0] TMO_PATTERN = 32'hDEAD_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    // Read data reported for an access abandoned by the ack watchdog.
    function automatic logic [GPIO_DW-1:0] tmo_rdata(input logic [GPIO_AW-1:0] addr);
        return TMO_PATTERN | {{(GPIO_DW-GPIO_AW){1'b0}}, addr};
    endfunction

endpackage

// File: rtl/gpio_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; grant is all-zero when no request is set.
module gpio_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    int            cand;
    logic [IW-1:0] cidx;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        cidx  = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cidx = IW'(cand);
            if (!found && req[cidx]) begin
                found     = 1'b1;
                gnt[cidx] = 1'b1;
                idx       = cidx;
            end
        end
    end

endmodule

// File: rtl/gpio_wb_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone slave among N_REQ requesters; GPIO_WB_ARB_TIMEOUT_EN adds an ack watchdog.
// Latency: bus cycle starts one cycle after the request is seen; done pulses one cycle after ack.
// Backpressure: requesters hold req_i until their done_o bit; one access in flight, IDLE/BUS/DONE minimum 3 cycles.
module gpio_wb_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       rst_n_i,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ-1:0]           we_i,
    input  logic [N_REQ*GPIO_AW-1:0]   addr_i,
    input  logic [N_REQ*GPIO_DW-1:0]   data_i,
    input  logic [N_REQ*GPIO_SW-1:0]   sel_i,
    output logic [N_REQ-1:0]           done_o,
    output logic                       err_o,
    output logic [GPIO_DW-1:0]         rdata_o,
    output logic [N_REQ-1:0]           gnt_o,
    output logic [GPIO_AW-1:0]         wb_addr_o,
    output logic [GPIO_DW-1:0]         wb_data_o,
    output logic [GPIO_SW-1:0]         wb_sel_o,
    output logic                       wb_we_o,
    output logic                       wb_cyc_o,
    output logic                       wb_stb_o,
    input  logic [GPIO_DW-1:0]         wb_data_i,
    input  logic                       wb_ack_i
);

    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("gpio_wb_arbiter: N_REQ must be 2..8 and TIMEOUT 1..255");
    end

    arb_state_e         state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic               we_q, we_d;
    logic [GPIO_AW-1:0] addr_q, addr_d;
    logic [GPIO_DW-1:0] data_q, data_d;
    logic [GPIO_SW-1:0] sel_q, sel_d;
    logic [GPIO_DW-1:0] rdata_q, rdata_d;
`ifdef GPIO_WB_ARB_TIMEOUT_EN
    logic [7:0]         cnt_q, cnt_d;
    logic               err_q, err_d;
`endif

    logic [N_REQ-1:0]   pick_gnt;
    logic [IW-1:0]      pick_idx;

    gpio_rr_pick #(.N(N_REQ)) u_pick (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
`ifdef GPIO_WB_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    we_d    = we_i[pick_idx];
                    addr_d  = addr_i[int'(pick_idx)*GPIO_AW +: GPIO_AW];
                    data_d  = data_i[int'(pick_idx)*GPIO_DW +: GPIO_DW];
                    sel_d   = sel_i[int'(pick_idx)*GPIO_SW +: GPIO_SW];
                    state_d = BUS;
`ifdef GPIO_WB_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUS: begin
                if (wb_ack_i) begin
                    if (!we_q) begin
                        rdata_d = wb_data_i;
                    end
                    state_d = DONE;
`ifdef GPIO_WB_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    // Slave is unresponsive: finish the access locally with a tagged error word.
                    rdata_d = tmo_rdata(addr_q);
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
`endif
                end
            end
            DONE: begin
                gnt_d   = '0;
                ptr_d   = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
`ifdef GPIO_WB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
`ifdef GPIO_WB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Wishbone strobes decode from the state flop only, so reset drops them asynchronously.
    assign wb_cyc_o  = (state_q == BUS);
    assign wb_stb_o  = (state_q == BUS);
    assign wb_we_o   = we_q;
    assign wb_addr_o = addr_q;
    assign wb_data_o = data_q;
    assign wb_sel_o  = sel_q;
    assign gnt_o     = gnt_q;
    assign done_o    = (state_q == DONE) ? gnt_q : '0;
    assign rdata_o   = rdata_q;
`ifdef GPIO_WB_ARB_TIMEOUT_EN
    assign err_o     = (state_q == DONE) && err_q;
`else
    assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// Directed bench for gpio_wb_arbiter with a small Wishbone slave model.
module tb_gpio_wb_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req, we;
    logic [N*3-1:0] addr;
    logic [N*32-1:0] data;
    logic [N*4-1:0] sel;
    logic [N-1:0]   done_o, gnt_o;
    logic           err_o;
    logic [31:0]    rdata_o;
    logic [2:0]     wb_addr_o;
    logic [31:0]    wb_data_o;
    logic [3:0]     wb_sel_o;
    logic           wb_we_o, wb_cyc_o, wb_stb_o;

    logic [31:0]    s_rdata;
    logic           s_ack;
    int             s_delay = 0;
    bit             s_mute  = 1'b0;
    int             wcnt;
    logic [2:0]     s_addr;
    logic [31:0]    s_wdata;
    logic [3:0]     s_sel;
    logic           s_we;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;
    logic cyc1;
    logic [N-1:0] gnt1;

    always #5 clk = ~clk;

    gpio_wb_arbiter #(.N_REQ(N), .TIMEOUT(16)) dut (
        .wb_clk_i  (clk),
        .rst_n_i   (rst_n),
        .req_i     (req),
        .we_i      (we),
        .addr_i    (addr),
        .data_i    (data),
        .sel_i     (sel),
        .done_o    (done_o),
        .err_o     (err_o),
        .rdata_o   (rdata_o),
        .gnt_o     (gnt_o),
        .wb_addr_o (wb_addr_o),
        .wb_data_o (wb_data_o),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_data_i (s_rdata),
        .wb_ack_i  (s_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave: acks after s_delay wait cycles and records what the master drove.
    initial begin
        s_ack = 1'b0;
        wcnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (wb_cyc_o && wb_stb_o && !s_mute) begin
                if (wcnt >= s_delay) begin
                    s_ack   = 1'b1;
                    s_addr  = wb_addr_o;
                    s_wdata = wb_data_o;
                    s_sel   = wb_sel_o;
                    s_we    = wb_we_o;
                    wcnt    = 0;
                end else begin
                    s_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                s_ack = 1'b0;
                wcnt  = 0;
            end
        end
    end

    task automatic set_req(input int i, input logic w, input logic [2:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        we[i]          = w;
        addr[3*i +: 3] = a;
        data[32*i +: 32] = d;
        sel[4*i +: 4]  = s;
        req[i]         = 1'b1;
    endtask

    // Counts falling edges until done_o shows, noting the first cycle's cyc and grant.
    task automatic run_to_done(output int n, output logic c1, output logic [N-1:0] g1);
        n  = 0;
        c1 = 1'b0;
        g1 = '0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                c1 = wb_cyc_o & wb_stb_o;
                g1 = gnt_o;
            end
        end while (done_o == '0 && n < 100);
        check("done_seen", 32'(|done_o), 32'h1);
    endtask

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        we      = '0;
        addr    = '0;
        data    = '0;
        sel     = '0;
        s_rdata = 32'h1234_5678;
        repeat (2) @(negedge clk);

        check("rst_gnt",   32'(gnt_o),    32'h0);
        check("rst_done",  32'(done_o),   32'h0);
        check("rst_cyc",   32'(wb_cyc_o), 32'h0);
        check("rst_stb",   32'(wb_stb_o), 32'h0);
        check("rst_rdata", rdata_o,       32'h0);
        check("rst_err",   32'(err_o),    32'h0);

        rst_n = 1'b1;
        @(negedge clk);

        // Single write from requester 0
        set_req(0, 1'b1, 3'h1, 32'hFFFF_0000, 4'hF);
        run_to_done(lat, cyc1, gnt1);
        check("wr_cyc_first", 32'(cyc1),   32'h1);
        check("wr_gnt_first", 32'(gnt1),   32'h1);
        check("wr_latency",   32'(lat),    32'd2);
        check("wr_done",      32'(done_o), 32'h1);
        check("wr_err",       32'(err_o),  32'h0);
        check("wr_addr",      32'(s_addr), 32'h1);
        check("wr_data",      s_wdata,     32'hFFFF_0000);
        check("wr_sel",       32'(s_sel),  32'hF);
        check("wr_we",        32'(s_we),   32'h1);
        check("wr_rdata_kept", rdata_o,    32'h0);
        check("wr_cyc_gap",   32'(wb_cyc_o), 32'h0);
        req = '0;
        @(negedge clk);

        // Read via requester 2, 3 wait states
        s_rdata = 32'hCAFE_BEEF;
        s_delay = 3;
        set_req(2, 1'b0, 3'h6, 32'h0, 4'hF);
        run_to_done(lat, cyc1, gnt1);
        check("rd_gnt_first", 32'(gnt1),   32'h4);
        check("rd_latency",   32'(lat),    32'd5);
        check("rd_done",      32'(done_o), 32'h4);
        check("rd_rdata",     rdata_o,     32'hCAFE_BEEF);
        check("rd_err",       32'(err_o),  32'h0);
        check("rd_addr",      32'(s_addr), 32'h6);
        check("rd_we",        32'(s_we),   32'h0);
        req = '0;
        @(negedge clk);

        // Requester 1 drops req while granted; requester 2 pending
        s_rdata = 32'h0BAD_F00D;
        s_delay = 1;
        set_req(1, 1'b1, 3'h2, 32'hA5A5_5A5A, 4'h3);
        set_req(2, 1'b1, 3'h4, 32'h0000_0077, 4'h1);
        @(negedge clk);
        check("drop_gnt", 32'(gnt_o),    32'h2);
        check("drop_cyc", 32'(wb_cyc_o), 32'h1);
        req[1] = 1'b0;
        run_to_done(lat, cyc1, gnt1);
        check("drop_latency", 32'(lat),    32'd2);
        check("drop_done",    32'(done_o), 32'h2);
        check("drop_addr",    32'(s_addr), 32'h2);
        check("drop_sel",     32'(s_sel),  32'h3);
        check("drop_rdata",   rdata_o,     32'hCAFE_BEEF);
        run_to_done(lat, cyc1, gnt1);
        check("next_latency", 32'(lat),    32'd4);
        check("next_done",    32'(done_o), 32'h4);
        check("next_addr",    32'(s_addr), 32'h4);
        req = '0;
        @(negedge clk);

        // Reset pulsed in the middle of a bus cycle
        s_mute = 1'b1;
        set_req(3, 1'b0, 3'h7, 32'h0, 4'hF);
        @(negedge clk);
        check("mid_gnt_pre", 32'(gnt_o),    32'h8);
        check("mid_cyc_pre", 32'(wb_cyc_o), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_cyc_async", 32'(wb_cyc_o), 32'h0);
        check("mid_stb_async", 32'(wb_stb_o), 32'h0);
        check("mid_gnt_async", 32'(gnt_o),    32'h0);
        req    = 4'b0110;
        s_mute = 1'b0;
        s_delay = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_to_done(lat, cyc1, gnt1);
        check("post_rst_gnt",  32'(gnt1),   32'h2);
        check("post_rst_done", 32'(done_o), 32'h2);
        req = '0;
        @(negedge clk);

        // All requesters held high from reset: strict rotation 0,1,2,3,0
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b1, 3'(i), 32'(i), 4'hF);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            run_to_done(lat, cyc1, gnt1);
            check("rr_done",    32'(done_o),   32'(1 << (j % 4)));
            check("rr_spacing", 32'(lat),      (j == 0) ? 32'd2 : 32'd3);
            check("rr_idle",    32'(wb_cyc_o), 32'h0);
        end
        req = '0;
        @(negedge clk);

`ifdef GPIO_WB_ARB_TIMEOUT_EN
        // Slave never acks requester 0; watchdog ends it, then requester 1 is served
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        s_mute = 1'b1;
        set_req(0, 1'b0, 3'h5, 32'h0, 4'hF);
        set_req(1, 1'b1, 3'h3, 32'h0000_0011, 4'hF);
        run_to_done(lat, cyc1, gnt1);
        check("tmo_latency", 32'(lat),    32'd17);
        check("tmo_done",    32'(done_o), 32'h1);
        check("tmo_err",     32'(err_o),  32'h1);
        check("tmo_rdata",   rdata_o,     32'hDEAD_0005);
        req[0] = 1'b0;
        s_mute = 1'b0;
        s_delay = 0;
        run_to_done(lat, cyc1, gnt1);
        check("tmo_next_latency", 32'(lat),    32'd3);
        check("tmo_next_done",    32'(done_o), 32'h2);
        check("tmo_next_err",     32'(err_o),  32'h0);
        req = '0;
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
